pipe_addsub: RTL

PIPE_ADDSUB -- requirements
Module: pipe_addsub

---
 rtl/pipe_addsub.sv | 100 ++++++++++
 1 files changed

// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined adder/subtractor with a valid/ready handshake.
// The arithmetic is done combinationally ahead of the first register, and the
// result then moves through STAGES register slices together with a valid bit.
// All slices hold while the output is valid and not accepted.
// Optional build macro: ADDSUB_SAT_EN clamps overflowed results. Without it,
// results wrap modulo 2^WIDTH. Latency is the same in both builds.
module pipe_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int SIGNED = 1
) (
   input  logic             clk,
   input  logic             AReset,
   input  logic             add_sub,
   input  logic [WIDTH-1:0] dataa,
   input  logic [WIDTH-1:0] datab,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             out_valid,
   input  logic             out_ready
);

   logic             advance;
   logic [WIDTH-1:0] b_op;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] res_d;
   logic             cout_d;
   logic             ovf_d;
   logic             sgn_ovf;

   logic [WIDTH-1:0] res_q  [STAGES];
   logic             cout_q [STAGES];
   logic             ovf_q  [STAGES];
   logic             vld_q  [STAGES];

   // Subtraction is computed as a + ~b + 1, so the carry out is already the
   // "no borrow" flag.
   always_comb begin
      b_op    = add_sub ? datab : ~datab;
      sum_ext = {1'b0, dataa} + {1'b0, b_op} + {{WIDTH{1'b0}}, ~add_sub};
      sum     = sum_ext[WIDTH-1:0];
      cout_d  = sum_ext[WIDTH];
      sgn_ovf = (dataa[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != dataa[WIDTH-1]);
      if (SIGNED != 0) begin
         ovf_d = sgn_ovf;
      end else begin
         ovf_d = add_sub ? cout_d : ~cout_d;
      end
      res_d = sum;
`ifdef ADDSUB_SAT_EN
      // The true result always has the sign of dataa whenever a signed overflow occurs.
      if (ovf_d) begin
         if (SIGNED != 0) begin
            res_d = dataa[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
         end else begin
            res_d = add_sub ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
         end
      end
`endif
   end

   // The pipeline moves only when the output slot is free or being consumed.
   always_comb begin
      advance  = !(out_valid && !out_ready);
      in_ready = advance;
   end

   // Pipeline registers. Reset wins over advance and discards in-flight operations.
   always_ff @(posedge clk) begin
      if (AReset) begin
         for (int i = 0; i < STAGES; i++) begin
            res_q[i]  <= '0;
            cout_q[i] <= 1'b0;
            ovf_q[i]  <= 1'b0;
            vld_q[i]  <= 1'b0;
         end
      end else if (advance) begin
         res_q[0]  <= res_d;
         cout_q[0] <= cout_d;
         ovf_q[0]  <= ovf_d;
         vld_q[0]  <= in_valid;
         for (int i = 1; i < STAGES; i++) begin
            res_q[i]  <= res_q[i-1];
            cout_q[i] <= cout_q[i-1];
            ovf_q[i]  <= ovf_q[i-1];
            vld_q[i]  <= vld_q[i-1];
         end
      end
   end

   assign result    = res_q[STAGES-1];
   assign cout      = cout_q[STAGES-1];
   assign overflow  = ovf_q[STAGES-1];
   assign out_valid = vld_q[STAGES-1];

endmodule
